// File: rtl/svm_pkg.sv
// svm_pkg: shared sizing constants and dimension helpers
// for the SVM weight/data vector store.
package svm_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MAX_DIM    = 32;
    localparam int DIM_W      = $clog2(MAX_DIM + 1);

    localparam logic [DATA_WIDTH-1:0] FP_ONE = 32'h3f800000;

    // Requested length forced into the legal range 1..max_dim.
    function automatic int unsigned clamp_dim(
        input int unsigned dim,
        input int unsigned max_dim
    );
        if (dim == 0)
            return 1;
        if (dim > max_dim)
            return max_dim;
        return dim;
    endfunction

    // A requested length the store cannot honour as given.
    function automatic logic dim_bad(
        input int unsigned dim,
        input int unsigned max_dim
    );
        return (dim == 0) || (dim > max_dim);
    endfunction

endpackage

// File: rtl/svm_vec_buf.sv
// svm_vec_buf: one MAX_DIM x DATA_WIDTH register vector with
// append counter, length latch, pad-on-clear and full flag.
module svm_vec_buf #(
    parameter int DATA_WIDTH = svm_pkg::DATA_WIDTH,
    parameter int MAX_DIM    = svm_pkg::MAX_DIM,
    parameter int DIM_W      = svm_pkg::DIM_W,
    parameter logic [DATA_WIDTH-1:0] PAD_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [DIM_W-1:0]              num_dim,
    output logic [MAX_DIM*DATA_WIDTH-1:0] vec_flat,
    output logic                          full,
    output logic                          dim_err
);

    import svm_pkg::*;

    logic [DIM_W-1:0] cnt;
    logic [DIM_W-1:0] dim_lat;
    logic             first;

    // The length is taken from the first beat of each vector.
    assign first   = wr_en && (cnt == '0);
    assign full    = (cnt != '0) && (cnt == dim_lat);
    assign dim_err = first && dim_bad(32'(num_dim), MAX_DIM);

    // Pad on reset/clear; otherwise append the word at cnt.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_flat <= {MAX_DIM{PAD_VAL}};
            cnt      <= '0;
            dim_lat  <= '0;
        end else if (wr_en && !full) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                if (cnt == DIM_W'(i))
                    vec_flat[i*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
            end
            cnt <= cnt + DIM_W'(1);
            if (first)
                dim_lat <= DIM_W'(clamp_dim(32'(num_dim), MAX_DIM));
        end
    end

endmodule

// File: rtl/svm_vec_bank_pp.sv
// svm_vec_bank_pp: weight bank plus ping-pong data buffers
// fed from a valid/ready stream, presented as flat buses.
module svm_vec_bank_pp #(
    parameter int DATA_WIDTH = svm_pkg::DATA_WIDTH,
    parameter int MAX_DIM    = svm_pkg::MAX_DIM,
    parameter int DIM_W      = $clog2(MAX_DIM + 1),
    parameter logic [DATA_WIDTH-1:0] DATA_PAD_VAL   = 32'h3f800000,
    parameter logic [DATA_WIDTH-1:0] WEIGHT_PAD_VAL = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_vld,
    output logic                          in_rdy,
    input  logic                          load_sel,
    input  logic [DIM_W-1:0]              num_dim,
    input  logic                          clear_weights,
    input  logic                          clear_data,
    input  logic                          data_consumed,
    output logic [MAX_DIM*DATA_WIDTH-1:0] weights_flat,
    output logic                          weights_progd,
    output logic [MAX_DIM*DATA_WIDTH-1:0] data_flat,
    output logic                          data_vld,
    output logic                          cfg_err
);

    logic                          fsel;
    logic                          acc;
    logic                          fill_full;
    logic                          swap;
    logic                          w_wr;
    logic                          b0_wr;
    logic                          b1_wr;
    logic                          b0_clr;
    logic                          b1_clr;
    logic                          b0_full;
    logic                          b1_full;
    logic                          w_err;
    logic                          b0_err;
    logic                          b1_err;
    logic [MAX_DIM*DATA_WIDTH-1:0] b0_flat;
    logic [MAX_DIM*DATA_WIDTH-1:0] b1_flat;

    // fsel names the fill buffer; the other one is active.
    assign fill_full = fsel ? b1_full : b0_full;
    assign data_flat = fsel ? b0_flat : b1_flat;

    // Any clear blocks the stream so no beat races a pad.
    assign in_rdy = !rst && !clear_weights && !clear_data &&
                    (load_sel ? !fill_full : !weights_progd);

    assign acc   = in_vld && in_rdy;
    assign w_wr  = acc && !load_sel;
    assign b0_wr = acc && load_sel && !fsel;
    assign b1_wr = acc && load_sel && fsel;

    // Full fill buffer moves to active once active is free.
    assign swap = fill_full && !clear_data &&
                  (!data_vld || data_consumed);

    // The outgoing active buffer is padded to become the fill.
    assign b0_clr = clear_data || (swap && fsel);
    assign b1_clr = clear_data || (swap && !fsel);

    svm_vec_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIM    (MAX_DIM),
        .DIM_W      (DIM_W),
        .PAD_VAL    (WEIGHT_PAD_VAL)
    ) u_wbuf (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_weights),
        .wr_en    (w_wr),
        .wr_data  (in_data),
        .num_dim  (num_dim),
        .vec_flat (weights_flat),
        .full     (weights_progd),
        .dim_err  (w_err)
    );

    svm_vec_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIM    (MAX_DIM),
        .DIM_W      (DIM_W),
        .PAD_VAL    (DATA_PAD_VAL)
    ) u_buf0 (
        .clk      (clk),
        .rst      (rst),
        .clear    (b0_clr),
        .wr_en    (b0_wr),
        .wr_data  (in_data),
        .num_dim  (num_dim),
        .vec_flat (b0_flat),
        .full     (b0_full),
        .dim_err  (b0_err)
    );

    svm_vec_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIM    (MAX_DIM),
        .DIM_W      (DIM_W),
        .PAD_VAL    (DATA_PAD_VAL)
    ) u_buf1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (b1_clr),
        .wr_en    (b1_wr),
        .wr_data  (in_data),
        .num_dim  (num_dim),
        .vec_flat (b1_flat),
        .full     (b1_full),
        .dim_err  (b1_err)
    );

    // Ping-pong select and active-vector valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsel     <= 1'b0;
            data_vld <= 1'b0;
        end else if (clear_data) begin
            data_vld <= 1'b0;
        end else if (swap) begin
            fsel     <= ~fsel;
            data_vld <= 1'b1;
        end else if (data_consumed) begin
            data_vld <= 1'b0;
        end
    end

    // Sticky flag for any out-of-range length request.
    always_ff @(posedge clk) begin
        if (rst)
            cfg_err <= 1'b0;
        else if (w_err || b0_err || b1_err)
            cfg_err <= 1'b1;
    end

endmodule

// File: tb/tb_svm_vec_bank_pp.sv
// tb_svm_vec_bank_pp: directed and random stimulus against a
// vector-level reference model of the weight/data store.
module tb_svm_vec_bank_pp;

    localparam int DW = 32;
    localparam int MD = 32;
    localparam int NW = 6;
    localparam logic [DW-1:0] PADD = 32'h3f800000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic              in_vld = 1'b0;
    logic              in_rdy;
    logic              load_sel = 1'b0;
    logic [NW-1:0]     num_dim = '0;
    logic              clear_weights = 1'b0;
    logic              clear_data = 1'b0;
    logic              data_consumed = 1'b0;
    logic [MD*DW-1:0]  weights_flat;
    logic              weights_progd;
    logic [MD*DW-1:0]  data_flat;
    logic              data_vld;
    logic              cfg_err;

    always #5 clk = ~clk;

    svm_vec_bank_pp dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .load_sel      (load_sel),
        .num_dim       (num_dim),
        .clear_weights (clear_weights),
        .clear_data    (clear_data),
        .data_consumed (data_consumed),
        .weights_flat  (weights_flat),
        .weights_progd (weights_progd),
        .data_flat     (data_flat),
        .data_vld      (data_vld),
        .cfg_err       (cfg_err)
    );

    // Reference model: loaded words, requested lengths, flags.
    logic [DW-1:0] mw [MD];
    logic [DW-1:0] mf [MD];
    logic [DW-1:0] ma [MD];
    int  mwc, mwd, mfc, mfd;
    bit  mvld, merr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] pushed [$];
    logic [DW-1:0] wv [$];
    logic [DW-1:0] v1 [$];
    logic [DW-1:0] v2 [$];

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MD) return MD;
        return d;
    endfunction

    function automatic bit m_wdone();
        return (mwc != 0) && (mwc == mwd);
    endfunction

    function automatic bit m_fdone();
        return (mfc != 0) && (mfc == mfd);
    endfunction

    function automatic bit m_rdy();
        if (rst || clear_weights || clear_data) return 1'b0;
        return load_sel ? !m_fdone() : !m_wdone();
    endfunction

    function automatic logic [MD*DW-1:0] packv(input logic [DW-1:0] v [MD]);
        logic [MD*DW-1:0] r;
        for (int i = 0; i < MD; i++) r[i*DW +: DW] = v[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < MD; i++) begin
            mw[i] = '0; mf[i] = PADD; ma[i] = PADD;
        end
        mwc = 0; mwd = 0; mfc = 0; mfd = 0;
        mvld = 1'b0; merr = 1'b0;
    endtask

    task automatic m_edge(input bit rdy);
        bit acc, ff;
        int nd;
        if (rst) begin m_reset(); return; end
        acc = in_vld && rdy;
        ff  = m_fdone();
        nd  = int'(num_dim);
        if (clear_weights) begin
            for (int i = 0; i < MD; i++) mw[i] = '0;
            mwc = 0; mwd = 0;
        end else if (acc && !load_sel) begin
            if (mwc == 0) begin
                mwd = clampd(nd);
                if (nd == 0 || nd > MD) merr = 1'b1;
            end
            mw[mwc] = in_data; mwc++;
        end
        if (clear_data) begin
            for (int i = 0; i < MD; i++) begin mf[i] = PADD; ma[i] = PADD; end
            mfc = 0; mfd = 0; mvld = 1'b0;
        end else if (ff && (!mvld || data_consumed)) begin
            for (int i = 0; i < MD; i++) begin ma[i] = mf[i]; mf[i] = PADD; end
            mfc = 0; mfd = 0; mvld = 1'b1;
        end else begin
            if (data_consumed) mvld = 1'b0;
            if (acc && load_sel) begin
                if (mfc == 0) begin
                    mfd = clampd(nd);
                    if (nd == 0 || nd > MD) merr = 1'b1;
                end
                mf[mfc] = in_data; mfc++;
            end
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [MD*DW-1:0] obs, input logic [MD*DW-1:0] exp);
        int w;
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            w = 0;
            for (int i = MD - 1; i >= 0; i--)
                if (obs[i*DW +: DW] !== exp[i*DW +: DW]) w = i;
            $error("FAIL %s: word %0d observed %h expected %h",
                   tag, w, obs[w*DW +: DW], exp[w*DW +: DW]);
        end
    endtask

    task automatic tick();
        bit r;
        #1;
        r = m_rdy();
        chk1("in_rdy", in_rdy, r);
        @(posedge clk);
        m_edge(r);
        #1;
        chk1("weights_progd", weights_progd, m_wdone());
        chk1("data_vld", data_vld, mvld);
        chk1("cfg_err", cfg_err, merr);
        chkv("weights_flat", weights_flat, packv(mw));
        chkv("data_flat", data_flat, packv(ma));
    endtask

    task automatic push(input int n, input bit ls, input logic [NW-1:0] nd);
        int got, cyc;
        bit r;
        got = 0; cyc = 0;
        pushed.delete();
        load_sel = ls; num_dim = nd; in_vld = 1'b1; in_data = $urandom;
        while (got < n && cyc < 80) begin
            r = m_rdy();
            tick();
            cyc++;
            if (r) begin
                pushed.push_back(in_data);
                got++;
                in_data = $urandom;
            end
        end
        in_vld = 1'b0;
        n_cmp++;
        assert (got == n) else begin
            n_bad++;
            $error("FAIL push_budget: observed %0d expected %0d", got, n);
        end
    endtask

    initial begin
        m_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("rst_vld", data_vld, 1'b0);
        chk1("rst_progd", weights_progd, 1'b0);
        chk32("rst_d5", data_flat[5*DW +: DW], PADD);

        // Weights, length 4, then a stalled fifth beat.
        push(4, 1'b0, 6'd4);
        wv = pushed;
        chk1("w_progd", weights_progd, 1'b1);
        chk32("w0", weights_flat[0 +: DW], wv[0]);
        chk32("w4_pad", weights_flat[4*DW +: DW], 32'h0);
        in_vld = 1'b1; load_sel = 1'b0;
        tick(); tick();
        chk1("w_stall", in_rdy, 1'b0);
        in_vld = 1'b0;

        // Data ping-pong, length 3.
        push(3, 1'b1, 6'd3);
        v1 = pushed;
        chk1("vld_lat1", data_vld, 1'b0);
        tick();
        chk1("vld_lat2", data_vld, 1'b1);
        chk32("act_v1_2", data_flat[2*DW +: DW], v1[2]);
        push(3, 1'b1, 6'd3);
        v2 = pushed;
        in_vld = 1'b1; load_sel = 1'b1;
        repeat (3) tick();
        chk1("d_stall", in_rdy, 1'b0);
        data_consumed = 1'b1;
        tick();
        data_consumed = 1'b0; in_vld = 1'b0;
        chk1("swap_vld", data_vld, 1'b1);
        chk32("act_v2_0", data_flat[0 +: DW], v2[0]);
        chk32("act_v2_3", data_flat[3*DW +: DW], PADD);

        // Consume in the first cycle the next fill is full.
        push(3, 1'b1, 6'd3);
        v1 = pushed;
        data_consumed = 1'b1;
        tick();
        data_consumed = 1'b0;
        chk1("cons_vld", data_vld, 1'b1);
        chk32("act_v3_1", data_flat[DW +: DW], v1[1]);

        // Out-of-range lengths.
        clear_data = 1'b1; tick(); clear_data = 1'b0;
        push(1, 1'b1, 6'd0);
        v1 = pushed;
        chk1("err_zero", cfg_err, 1'b1);
        tick();
        chk32("len1_0", data_flat[0 +: DW], v1[0]);
        chk32("len1_1", data_flat[DW +: DW], PADD);
        clear_weights = 1'b1; tick(); clear_weights = 1'b0;
        push(32, 1'b0, 6'd40);
        wv = pushed;
        chk1("len40_progd", weights_progd, 1'b1);
        chk32("w31", weights_flat[31*DW +: DW], wv[31]);

        // clear_data against a beat and a pending swap.
        clear_weights = 1'b1; tick(); clear_weights = 1'b0;
        push(2, 1'b0, 6'd4);
        wv = pushed;
        push(3, 1'b1, 6'd3);
        clear_data = 1'b1; data_consumed = 1'b1;
        in_vld = 1'b1; load_sel = 1'b0;
        tick();
        clear_data = 1'b0; data_consumed = 1'b0; in_vld = 1'b0;
        chk1("clr_vld", data_vld, 1'b0);
        chkv("clr_pad", data_flat, {MD{PADD}});
        chk32("clr_w1", weights_flat[DW +: DW], wv[1]);
        chk32("clr_w2", weights_flat[2*DW +: DW], 32'h0);

        // Reset mid-vector, then reload from index 0.
        push(1, 1'b1, 6'd4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk1("mid_rst_progd", weights_progd, 1'b0);
        chkv("mid_rst_w", weights_flat, '0);
        push(4, 1'b0, 6'd4);
        wv = pushed;
        chk32("reload_w0", weights_flat[0 +: DW], wv[0]);
        chk1("reload_progd", weights_progd, 1'b1);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rst           = ($urandom_range(0, 199) == 0);
            clear_weights = ($urandom_range(0, 39) == 0);
            clear_data    = ($urandom_range(0, 39) == 0);
            data_consumed = ($urandom_range(0, 3) == 0);
            load_sel      = $urandom_range(0, 1);
            in_vld        = ($urandom_range(0, 3) != 0);
            in_data       = $urandom;
            if ($urandom_range(0, 9) == 0)
                num_dim = NW'($urandom_range(0, 40));
            else
                num_dim = NW'($urandom_range(1, 6));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
